// File: rtl/sma_sched_pkg.sv
// Shared types and the round-robin search helper for the SMA channel scheduler.
package sma_sched_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  typedef logic [15:0] sample_t;

  localparam int unsigned MAX_CH = 32;

  // Searches channels lo..nch-1 starting just after 'last'; returns nch when nobody requests.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] req, input int unsigned last,
                                          input int unsigned lo, input int unsigned nch);
    int unsigned n;
    int unsigned base;
    int unsigned idx;
    logic        found;
    n       = nch - lo;
    base    = (last >= lo) ? last - lo : n - 1;
    rr_pick = nch;
    found   = 1'b0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      if (!found && k <= n) begin
        idx = base + k;
        if (idx >= n) idx = idx - n;
        if ((req & (MAX_CH'(1) << (lo + idx))) != '0) begin
          rr_pick = lo + idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/sma_res_fifo.sv
// First-word-fall-through result FIFO; a write when full is dropped unless a read frees a slot.
module sma_res_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 18,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sma_channel_scheduler.sv
// Round-robin scheduler sharing one SMA engine among NCH channels, with credit-guarded results.
// Define SMA_SCHED_PRIO_EN to give channel 0 strict priority over the round-robin group.
module sma_channel_scheduler
  import sma_sched_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned RES_DEPTH = 8,
  localparam int unsigned CHW = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NCH-1:0]      in_valid,
  input  sample_t [NCH-1:0]   in_data,
  output logic [NCH-1:0]      in_ready,
  input  logic                flush_req,
  output logic                flush_busy,
  output logic                eng_valid,
  output logic [CHW-1:0]      eng_ch,
  output sample_t             eng_data,
  output logic                eng_prime,
  input  logic                eng_res_valid,
  input  logic [CHW-1:0]      eng_res_ch,
  input  sample_t             eng_res_data,
  output logic                out_valid,
  output logic [CHW-1:0]      out_ch,
  output sample_t             out_data,
  input  logic                out_ready,
  output logic                err_ovf
);

  localparam int unsigned CW = $clog2(RES_DEPTH + 1);

  state_t            state_q, state_d;
  logic [NCH-1:0]    primed_q, primed_d;
  logic [CHW-1:0]    rr_last_q;
  logic [CW-1:0]     credits_q, credits_d;
  logic              eng_valid_q, eng_prime_q, err_ovf_q;
  logic [CHW-1:0]    eng_ch_q;
  sample_t           eng_data_q;
  logic [MAX_CH-1:0] req;
  int unsigned       pick;
  logic              grant_ok;
  logic [CHW-1:0]    gsel;
  logic              pop;
  logic              res_full, res_empty;
  logic [CW-1:0]     res_count;
  logic [CHW+15:0]   res_head;

  always_comb begin
    req           = '0;
    req[NCH-1:0]  = in_valid;
`ifdef SMA_SCHED_PRIO_EN
    pick = in_valid[0] ? 32'd0 : rr_pick(req, 32'(rr_last_q), 32'd1, NCH);
`else
    pick = rr_pick(req, 32'(rr_last_q), 32'd0, NCH);
`endif
    grant_ok = (state_q == RUN) && (credits_q != '0) && (pick < NCH);
    gsel     = CHW'(pick);
    in_ready = '0;
    if (grant_ok) in_ready[gsel] = 1'b1;
  end

  assign pop = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    primed_d  = primed_q;
    credits_d = credits_q;
    unique case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   if (credits_q == CW'(RES_DEPTH)) state_d = CLEAR;
      CLEAR: begin
        state_d  = RUN;
        primed_d = '0;
      end
      default: state_d = RUN;
    endcase
    if (grant_ok) primed_d[gsel] = 1'b1;
    if (grant_ok && !pop) credits_d = credits_q - CW'(1);
    else if (!grant_ok && pop) credits_d = credits_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      primed_q    <= '0;
      rr_last_q   <= CHW'(NCH - 1);
      credits_q   <= CW'(RES_DEPTH);
      eng_valid_q <= 1'b0;
      eng_ch_q    <= '0;
      eng_data_q  <= '0;
      eng_prime_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      primed_q    <= primed_d;
      credits_q   <= credits_d;
      eng_valid_q <= grant_ok;
      if (grant_ok) begin
        rr_last_q   <= gsel;
        eng_ch_q    <= gsel;
        eng_data_q  <= in_data[gsel];
        eng_prime_q <= !primed_q[gsel];
      end
      if (eng_res_valid && res_full && !pop) err_ovf_q <= 1'b1;
    end
  end

  sma_res_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (CHW + 16)
  ) u_res_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (eng_res_valid),
    .wr_data ({eng_res_ch, eng_res_data}),
    .rd_en   (pop),
    .rd_data (res_head),
    .full    (res_full),
    .empty   (res_empty),
    .count   (res_count)
  );

  // The FIFO's empty flag and occupancy must never disagree.
  assert property (@(posedge clk) disable iff (!reset_n) res_empty == (res_count == '0));

  assign flush_busy = (state_q != RUN);
  assign eng_valid  = eng_valid_q;
  assign eng_ch     = eng_ch_q;
  assign eng_data   = eng_data_q;
  assign eng_prime  = eng_prime_q;
  assign out_valid  = !res_empty;
  assign out_ch     = res_head[CHW+15:16];
  assign out_data   = res_head[15:0];
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_sma_channel_scheduler.sv
// Bench for sma_channel_scheduler: cycle reference model plus directed and random stimulus.
module tb_sma_channel_scheduler;
  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  localparam int CHW   = 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NCH-1:0]       in_valid = '0;
  logic [NCH-1:0][15:0] in_data = '0;
  logic [NCH-1:0]       in_ready;
  logic                 flush_req = 1'b0;
  logic                 flush_busy;
  logic                 eng_valid;
  logic [CHW-1:0]       eng_ch;
  logic [15:0]          eng_data;
  logic                 eng_prime;
  logic                 eng_res_valid = 1'b0;
  logic [CHW-1:0]       eng_res_ch = '0;
  logic [15:0]          eng_res_data = '0;
  logic                 out_valid;
  logic [CHW-1:0]       out_ch;
  logic [15:0]          out_data;
  logic                 out_ready = 1'b0;
  logic                 err_ovf;

  always #5 clk = ~clk;

  sma_channel_scheduler #(
    .NCH       (NCH),
    .RES_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .flush_req     (flush_req),
    .flush_busy    (flush_busy),
    .eng_valid     (eng_valid),
    .eng_ch        (eng_ch),
    .eng_data      (eng_data),
    .eng_prime     (eng_prime),
    .eng_res_valid (eng_res_valid),
    .eng_res_ch    (eng_res_ch),
    .eng_res_data  (eng_res_data),
    .out_valid     (out_valid),
    .out_ch        (out_ch),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .err_ovf       (err_ovf)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: state as the rules describe it, not as the RTL encodes it.
  bit              m_primed [NCH];
  int              m_rr_last;
  int              m_credits;
  int              m_state;     // 0 run, 1 drain, 2 clear
  bit              m_err;
  bit              m_ev;
  bit              m_eprime;
  int              m_ech;
  logic [15:0]     m_edata;
  logic [CHW+15:0] m_q [$];

  // Engine stand-in: echoes each issue as data+1 after a random delay.
  logic [CHW+15:0] eng_pend [$];
  bit              echo_en  = 1'b0;
  int              echo_pct = 100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_primed[i] = 1'b0;
    m_rr_last = NCH - 1;
    m_credits = DEPTH;
    m_state   = 0;
    m_err     = 1'b0;
    m_ev      = 1'b0;
    m_q.delete();
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    in_valid      = '0;
    flush_req     = 1'b0;
    out_ready     = 1'b0;
    eng_res_valid = 1'b0;
    eng_pend.delete();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // One clock: check outputs at the falling edge, advance the model, then drive the engine.
  task automatic cycle();
    int             g;
    logic [NCH-1:0] er;
    bit             hs;
    bit             pop;
    bit             was_full;
    @(negedge clk);
    g = -1;
    if (m_state == 0 && m_credits > 0) begin
`ifdef SMA_SCHED_PRIO_EN
      if (in_valid[0]) g = 0;
      else
        for (int k = 1; k < NCH && g < 0; k++) begin
          int c;
          c = (m_rr_last + NCH - 2 + k) % (NCH - 1) + 1;
          if (in_valid[c]) g = c;
        end
`else
      for (int k = 1; k <= NCH && g < 0; k++) begin
        int c;
        c = (m_rr_last + k) % NCH;
        if (in_valid[c]) g = c;
      end
`endif
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready", in_ready, er);
    chk("eng_valid", eng_valid, m_ev);
    if (m_ev) begin
      chk("eng_ch", eng_ch, m_ech);
      chk("eng_data", eng_data, m_edata);
      chk("eng_prime", eng_prime, m_eprime);
    end
    chk("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("out_ch", out_ch, m_q[0][CHW+15:16]);
      chk("out_data", out_data, m_q[0][15:0]);
    end
    chk("flush_busy", flush_busy, m_state != 0);
    chk("err_ovf", err_ovf, m_err);
    if (echo_en && eng_valid) eng_pend.push_back({eng_ch, eng_data + 16'd1});

    hs       = (g >= 0);
    pop      = (m_q.size() > 0) && out_ready;
    was_full = (m_q.size() == DEPTH);
    case (m_state)
      0: if (flush_req) m_state = 1;
      1: if (m_credits == DEPTH) m_state = 2;
      default: begin
        m_state = 0;
        for (int i = 0; i < NCH; i++) m_primed[i] = 1'b0;
      end
    endcase
    m_ev = hs;
    if (hs) begin
      m_ech       = g;
      m_edata     = in_data[g];
      m_eprime    = !m_primed[g];
      m_primed[g] = 1'b1;
      m_rr_last   = g;
    end
    m_credits = m_credits + int'(pop) - int'(hs);
    if (pop) void'(m_q.pop_front());
    if (eng_res_valid) begin
      if (was_full && !pop) m_err = 1'b1;
      else m_q.push_back({eng_res_ch, eng_res_data});
    end

    @(posedge clk); #1;
    eng_res_valid = 1'b0;
    if (echo_en && eng_pend.size() > 0 && $urandom_range(99) < echo_pct) begin
      eng_res_valid = 1'b1;
      {eng_res_ch, eng_res_data} = eng_pend.pop_front();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_ch;

    // Reset state
    do_reset();
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_eng_valid", eng_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flush_busy", flush_busy, 0);
    chk("rst_err_ovf", err_ovf, 0);

    // First sample of a channel primes, the second does not
    echo_en   = 1'b1;
    echo_pct  = 100;
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    in_data[2] = 16'h0100;
    #1 chk("prime_ready", in_ready, 4'b0100);
    cycle();
    in_valid = '0;
    chk("prime_ev", eng_valid, 1);
    chk("prime_ch", eng_ch, 2);
    chk("prime_data", eng_data, 16'h0100);
    chk("prime_first", eng_prime, 1);
    cycle();
    chk("prime_pulse", eng_valid, 0);
    in_valid   = 4'b0100;
    in_data[2] = 16'h0180;
    cycle();
    in_valid = '0;
    chk("prime_second_ev", eng_valid, 1);
    chk("prime_second", eng_prime, 0);
    repeat (6) cycle();

    // All channels requesting: one grant per cycle in rotation
    do_reset();
    echo_en   = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < NCH; c++) in_data[c] = 16'(c * 16'h0100 + i);
      cycle();
`ifdef SMA_SCHED_PRIO_EN
      exp_ch = 0;
`else
      exp_ch = i % NCH;
`endif
      chk("rr_ev", eng_valid, 1);
      chk("rr_ch", eng_ch, exp_ch);
    end
    in_valid = '0;
    repeat (8) cycle();

    // Channels 0 and 3 only
    do_reset();
    echo_en   = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      cycle();
`ifdef SMA_SCHED_PRIO_EN
      exp_ch = 0;
`else
      exp_ch = (i % 2 == 0) ? 0 : 3;
`endif
      chk("pair_ch", eng_ch, exp_ch);
    end
    in_valid = '0;
    repeat (8) cycle();

    // Credits stop issue at RES_DEPTH outstanding; one pop releases exactly one more
    do_reset();
    echo_en   = 1'b1;
    out_ready = 1'b0;
    in_valid  = 4'hF;
    n = 0;
    repeat (20) begin
      cycle();
      n += int'(eng_valid);
    end
    chk("credit_issues", n, DEPTH);
    #1 chk("credit_blocked", in_ready, 0);
    chk("credit_no_ovf", err_ovf, 0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    n = 0;
    repeat (8) begin
      cycle();
      n += int'(eng_valid);
    end
    chk("credit_one_more", n, 1);
    chk("credit_still_no_ovf", err_ovf, 0);

    // Flush waits for all results to be popped, then re-primes
    do_reset();
    echo_en    = 1'b1;
    out_ready  = 1'b0;
    in_valid   = 4'b0010;
    in_data[1] = 16'h0200;
    repeat (3) cycle();
    in_valid = '0;
    repeat (4) cycle();
    chk("flush_pending", out_valid, 1);
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    chk("flush_busy_set", flush_busy, 1);
    in_valid = 4'hF;
    #1 chk("flush_no_ready", in_ready, 0);
    n = 0;
    repeat (5) begin
      cycle();
      n += int'(eng_valid);
    end
    chk("flush_no_grant", n, 0);
    chk("flush_busy_hold", flush_busy, 1);
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (3) cycle();
    out_ready = 1'b0;
    n = 0;
    while (flush_busy && n < 10) begin
      cycle();
      n++;
    end
    chk("flush_done", flush_busy, 0);
    in_valid = 4'b0010;
    cycle();
    in_valid = '0;
    chk("flush_reprime_ev", eng_valid, 1);
    chk("flush_reprime_ch", eng_ch, 1);
    chk("flush_reprime", eng_prime, 1);
    out_ready = 1'b1;
    repeat (6) cycle();

    // Engine write into a full FIFO is dropped and latches err_ovf
    do_reset();
    echo_en   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      eng_res_valid = 1'b1;
      eng_res_ch    = CHW'(i % NCH);
      eng_res_data  = 16'(16'h1000 + i);
      cycle();
    end
    chk("ovf_not_yet", err_ovf, 0);
    eng_res_valid = 1'b1;
    eng_res_ch    = 2'd3;
    eng_res_data  = 16'hDEAD;
    cycle();
    chk("ovf_set", err_ovf, 1);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_keep_valid", out_valid, 1);
      chk("ovf_keep_ch", out_ch, i % NCH);
      chk("ovf_keep_data", out_data, 16'h1000 + i);
      cycle();
    end
    out_ready = 1'b0;
    chk("ovf_drained", out_valid, 0);
    chk("ovf_sticky", err_ovf, 1);

    // Random traffic against the model, with one reset in the middle
    do_reset();
    echo_en  = 1'b1;
    echo_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      in_valid = NCH'($urandom);
      for (int c = 0; c < NCH; c++) in_data[c] = 16'($urandom);
      out_ready = ($urandom_range(99) < 70);
      flush_req = ($urandom_range(99) < 3);
      cycle();
    end
    flush_req = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (20) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
